// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over a req/ready handshake,
// presents the word to the decoders and resolves the next PC on retire.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] PC_RST =
    {RESET_PC[31:2], 2'b00};
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_ERROR
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [CW-1:0] wait_q;
  logic          req_q;
  logic          vld_q;
  logic          err_q;

  logic [31:0]   pc_plus4_w;
  logic [31:0]   jump_tgt;
  logic [31:0]   br_tgt;
  logic [31:0]   next_pc_d;
  logic [CW-1:0] wait_d;

  // Resolve the successor PC of the presented instruction; jump beats branch.
  always_comb begin
    pc_plus4_w = pc_q + 32'd4;
    jump_tgt   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    br_tgt     = pc_plus4_w + (branch_offset << 2);
    wait_d     = wait_q + CW'(1);
    next_pc_d  = pc_plus4_w;
    if (jump) begin
      next_pc_d = jump_tgt;
    end else if (branch_taken) begin
      next_pc_d = br_tgt;
    end
  end

  // Fetch FSM with registered handshake, valid and fault outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      instr_q <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          wait_q  <= '0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= S_VALID;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end else if (wait_d == WAIT_LIM) begin
            wait_q  <= wait_d;
            state_q <= S_ERROR;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wait_q  <= wait_d;
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc_q    <= next_pc_d;
            state_q <= S_FETCH;
            vld_q   <= 1'b0;
            req_q   <= 1'b1;
            wait_q  <= '0;
          end
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect table, handshake
// corner cases and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump(jump),
    .instr_valid(instr_valid),
    .instr(instr),
    .opcode(opcode),
    .funct(funct),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .fetch_err(fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instruction memory: explicit words, otherwise a hash of the address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Responder modes: 0 zero-wait, 1 fixed delay, 2 never, 3 random.
  int mode = 0;
  int dly  = 0;
  int wcnt = 0;
  bit force_rdy = 1'b0;

  always @(posedge clk) begin
    logic r;
    #1;
    if (imem_req) wcnt++;
    else wcnt = 0;
    case (mode)
      0: r = 1'b1;
      1: r = (wcnt > dly);
      2: r = 1'b0;
      default: r = (wcnt >= 8) || ($urandom_range(0, 1) == 1);
    endcase
    if (force_rdy) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req) begin
      imem_ready = r;
      imem_rdata = mem_rd(imem_addr);
    end else begin
      imem_ready = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    branch_offset = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(string nm);
    int k = 0;
    while (!instr_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!instr_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: instr_valid timeout, got 0 expected 1", nm);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        j;
    logic        b;
    logic [31:0] off;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] w;
    logic [31:0] exp_pc;
    logic [31:0] nxt;
    logic [31:0] pc4;
    logic [31:0] off;
    logic        j;
    logic        b;
    int          nf;
    int          k;
    bit          bad;
    bit          hold_bad;

    tbl[0]  = '{32'h0000_0000, 32'h2008_0005, 0, 0, 32'h0, 32'h0000_0004};
    tbl[1]  = '{32'h0000_0004, 32'h0800_0010, 1, 0, 32'h0, 32'h0000_0040};
    tbl[2]  = '{32'h0000_0040, 32'h0800_0010, 0, 1, 32'hFFFF_FFFE,
                32'h0000_003C};
    tbl[3]  = '{32'h0000_003C, 32'h0800_0010, 1, 1, 32'hFFFF_FFFE,
                32'h0000_0040};
    tbl[4]  = '{32'h0000_0040, 32'h0800_0010, 0, 0, 32'h0, 32'h0000_0044};
    tbl[5]  = '{32'h0000_0044, 32'h0BFF_FFFF, 1, 0, 32'h0, 32'h0FFF_FFFC};
    tbl[6]  = '{32'h0FFF_FFFC, 32'h1234_5678, 0, 1, 32'h0000_0001,
                32'h1000_0004};
    tbl[7]  = '{32'h1000_0004, 32'h0BFF_FFFF, 1, 0, 32'h0, 32'h1FFF_FFFC};
    tbl[8]  = '{32'h1FFF_FFFC, 32'h0000_0000, 0, 1, 32'hF7FF_FFFF,
                32'hFFFF_FFFC};
    tbl[9]  = '{32'hFFFF_FFFC, 32'hFC00_003F, 0, 0, 32'h0, 32'h0000_0000};
    tbl[10] = '{32'h0000_0000, 32'h2008_0005, 0, 0, 32'h0, 32'h0000_0004};
    foreach (tbl[i]) mem[tbl[i].addr] = tbl[i].word;
    mem[32'h0020_0014] = 32'h0800_0040;

    // Reset state and first-fetch latency.
    mode = 0;
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_err", fetch_err, 0);
    @(negedge clk);
    chk("c2_req", imem_req, 1);
    chk("c2_addr", imem_addr, 0);
    @(negedge clk);
    chk("c3_valid", instr_valid, 1);

    // Redirect table, chained: each entry starts where the last one went.
    for (int i = 0; i < 11; i++) begin
      wait_valid("tbl_wait");
      w = tbl[i].word;
      chk("tbl_pc", pc, tbl[i].addr);
      chk("tbl_instr", instr, w);
      chk("tbl_opcode", {26'b0, opcode}, {26'b0, w[31:26]});
      chk("tbl_funct", {26'b0, funct}, {26'b0, w[5:0]});
      chk("tbl_pc4", pc_plus4, tbl[i].addr + 32'd4);
      jump = tbl[i].j;
      branch_taken = tbl[i].b;
      branch_offset = tbl[i].off;
      @(negedge clk);
      jump = 1'b0;
      branch_taken = 1'b0;
      branch_offset = '0;
      chk("tbl_req", imem_req, 1);
      chk("tbl_next", imem_addr, tbl[i].nxt);
    end

    // Delayed ready: six FETCH cycles with a stable request.
    mode = 1;
    dly = 5;
    do_reset();
    nf = 0;
    bad = 0;
    k = 0;
    while (!instr_valid && k < 60) begin
      @(negedge clk);
      k++;
      if (imem_req) begin
        nf++;
        if (imem_addr !== 32'h0) bad = 1;
      end
    end
    chk("dly_fetch_cycles", nf, 6);
    chk("dly_addr_stable", {31'b0, bad}, 0);
    chk("dly_valid", instr_valid, 1);
    chk("dly_instr", instr, 32'h2008_0005);
    chk("dly_err", fetch_err, 0);

    // Memory never answers: timeout fault after MAX_WAIT cycles.
    mode = 2;
    do_reset();
    nf = 0;
    k = 0;
    while (!fetch_err && k < 60) begin
      @(negedge clk);
      k++;
      if (imem_req) nf++;
    end
    chk("to_fetch_cycles", nf, 16);
    chk("to_err", fetch_err, 1);
    chk("to_req", imem_req, 0);
    chk("to_valid", instr_valid, 0);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", fetch_err, 1);
    chk("to_req_idle", imem_req, 0);
    mode = 0;
    do_reset();
    chk("to_err_clr", fetch_err, 0);
    @(negedge clk);
    chk("to_restart_req", imem_req, 1);
    chk("to_restart_addr", imem_addr, 0);

    // Stall hold with jump toggling; release-cycle jump decides.
    wait_valid("stall_wait");
    chk("stall_pc0", pc, 0);
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      jump = ~s[0];
      @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_instr", instr, 32'h2008_0005);
    end
    stall = 1'b0;
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    chk("stall_rel_req", imem_req, 1);
    chk("stall_rel_addr", imem_addr, 32'h0020_0014);

    // Reset mid-FETCH, late ready while held in reset is ignored.
    wait_valid("rstf_wait");
    chk("rstf_pc", pc, 32'h0020_0014);
    mode = 1;
    dly = 3;
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    chk("rstf_req", imem_req, 1);
    chk("rstf_addr", imem_addr, 32'h0000_0100);
    rst = 1'b1;
    force_rdy = 1'b1;
    @(negedge clk);
    chk("rstf_req_drop", imem_req, 0);
    chk("rstf_valid", instr_valid, 0);
    chk("rstf_pc_rst", pc, 0);
    rst = 1'b0;
    force_rdy = 1'b0;
    mode = 0;
    @(negedge clk);
    chk("rstf_refetch_req", imem_req, 1);
    chk("rstf_refetch_addr", imem_addr, 0);
    wait_valid("rstf_wait2");
    chk("rstf_instr", instr, 32'h2008_0005);
    chk("rstf_pc_after", pc, 0);

    // Randomized run against a transaction-level PC model.
    mode = 3;
    do_reset();
    exp_pc = 32'h0;
    hold_bad = 0;
    for (int t = 0; t < 250; t++) begin
      bad = 0;
      k = 0;
      while (!instr_valid && k < 60) begin
        if (imem_req && imem_addr !== exp_pc) bad = 1;
        @(negedge clk);
        k++;
      end
      chk("rnd_valid", instr_valid, 1);
      chk("rnd_addr", {31'b0, bad}, 0);
      chk("rnd_pc", pc, exp_pc);
      chk("rnd_instr", instr, mem_rd(exp_pc));
      chk("rnd_pc4", pc_plus4, exp_pc + 32'd4);
      w = mem_rd(exp_pc);
      k = $urandom_range(0, 2);
      for (int s = 0; s < k; s++) begin
        stall = 1'b1;
        jump = $urandom_range(0, 1);
        branch_taken = $urandom_range(0, 1);
        branch_offset = $urandom;
        @(negedge clk);
        if (!instr_valid || imem_req || instr !== w || pc !== exp_pc)
          hold_bad = 1;
      end
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      off = $urandom;
      stall = 1'b0;
      jump = j;
      branch_taken = b;
      branch_offset = off;
      pc4 = exp_pc + 32'd4;
      if (j)      nxt = (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
      else if (b) nxt = pc4 + off * 4;
      else        nxt = pc4;
      @(negedge clk);
      jump = 1'b0;
      branch_taken = 1'b0;
      branch_offset = '0;
      exp_pc = nxt;
    end
    chk("rnd_stall_hold", {31'b0, hold_bad}, 0);
    chk("rnd_err", fetch_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
